// File: rtl/prog_loader_if.sv
// Byte-stream + debug-write bus between a program source, prog_loader and cpuCore.
//  byte_valid/byte_data : stream byte offered by the source
//  byte_ready           : loader accepts the byte this cycle
//  dbg_wr_en            : one-cycle instruction write strobe
//  dbg_addr/dbg_instr   : byte address and instruction word of the write
// slave  = loader side (consumes bytes, drives the debug write port)
// master = source/core side
interface prog_loader_if #(
   parameter int unsigned XLEN = 32
);
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic            dbg_wr_en;
   logic [XLEN-1:0] dbg_addr;
   logic [XLEN-1:0] dbg_instr;

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, dbg_wr_en, dbg_addr, dbg_instr
   );

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, dbg_wr_en, dbg_addr, dbg_instr
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader for cpuCore's debug instruction-write port.
// Takes a byte stream framed as a 16-bit little-endian word count N followed by
// N little-endian 32-bit words, writes each word to consecutive word addresses
// starting at BASE_ADDR, and holds the core in reset until the load completes.
//  clk        : clock, rising edge
//  rst        : synchronous active-high reset
//  load_start : one-cycle pulse, starts a load from IDLE, DONE or ERR
//  bus        : byte stream in, debug write port out (slave modport)
//  core_rst   : reset to cpuCore, low only once a program is loaded
//  load_done  : high in DONE
//  load_err   : high in ERR (word count above MAX_WORDS)
module prog_loader #(
   parameter int unsigned    XLEN      = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = '0,
   parameter int unsigned    MAX_WORDS = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   prog_loader_if.slave       bus,
   output logic               core_rst,
   output logic               load_done,
   output logic               load_err
);

   localparam int unsigned NW = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t          state_q;
   logic            byte_ready_q;
   logic            wr_en_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] instr_q;
   logic            core_rst_q;
   logic            done_q;
   logic            err_q;
   logic [NW-1:0]   n_q;
   logic [NW-1:0]   idx_q;
   logic [1:0]      bcnt_q;
   logic [23:0]     word_q;   // first three bytes of the word being assembled

   logic            xfer_c;
   logic [NW-1:0]   hdr_n_c;
   logic [NW-1:0]   idx_nxt_c;

   // Handshake and header/index helpers
   always_comb begin
      xfer_c    = bus.byte_valid & byte_ready_q;
      hdr_n_c   = {bus.byte_data, n_q[7:0]};
      idx_nxt_c = NW'(idx_q + NW'(1));
   end

   // Loader FSM; every output is registered and set on entry to its state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         addr_q       <= '0;
         instr_q      <= '0;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         n_q          <= '0;
         idx_q        <= '0;
         bcnt_q       <= '0;
         word_q       <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_start) begin
                  state_q      <= S_HDR0;
                  byte_ready_q <= 1'b1;
               end
            end
            S_HDR0: begin
               if (xfer_c) begin
                  n_q[7:0] <= bus.byte_data;
                  state_q  <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (xfer_c) begin
                  n_q    <= hdr_n_c;
                  idx_q  <= '0;
                  bcnt_q <= '0;
                  if (hdr_n_c == '0) begin
                     state_q      <= S_DONE;
                     byte_ready_q <= 1'b0;
                     core_rst_q   <= 1'b0;
                     done_q       <= 1'b1;
                  end else if (32'(hdr_n_c) > 32'(MAX_WORDS)) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer_c) begin
                  word_q <= {bus.byte_data, word_q[23:8]};
                  bcnt_q <= 2'(bcnt_q + 2'd1);
                  if (bcnt_q == 2'd3) begin
                     instr_q      <= XLEN'({bus.byte_data, word_q});
                     addr_q       <= BASE_ADDR + XLEN'({idx_q, 2'b00});
                     wr_en_q      <= 1'b1;
                     byte_ready_q <= 1'b0;
                     state_q      <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               idx_q <= idx_nxt_c;
               if (idx_nxt_c == n_q) begin
                  state_q    <= S_DONE;
                  core_rst_q <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  state_q      <= S_DATA;
                  byte_ready_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (load_start) begin
                  state_q      <= S_HDR0;
                  byte_ready_q <= 1'b1;
                  core_rst_q   <= 1'b1;
                  done_q       <= 1'b0;
               end
            end
            S_ERR: begin
               // Keeps byte_ready high so the rest of the stream drains
               if (load_start) begin
                  state_q <= S_HDR0;
                  err_q   <= 1'b0;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               byte_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.dbg_wr_en  = wr_en_q;
   assign bus.dbg_addr   = addr_q;
   assign bus.dbg_instr  = instr_q;
   assign core_rst       = core_rst_q;
   assign load_done      = done_q;
   assign load_err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE_ADDR 0 and 0x100), expected
// writes queued when stimulus is driven and compared when dbg_wr_en pulses.
module tb_prog_loader;

   localparam int unsigned MAXW = 1024;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
   } wr_t;

   logic clk;
   logic rst0, rst1;
   logic start0, start1;
   logic core_rst0, core_rst1, done0, done1, err0, err1;

   int checks = 0;
   int errors = 0;
   int wr_cnt0 = 0;
   int wr_cnt1 = 0;
   wr_t q0[$];
   wr_t q1[$];

   prog_loader_if #(.XLEN(32)) if0 ();
   prog_loader_if #(.XLEN(32)) if1 ();

   prog_loader #(.XLEN(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut0 (
      .clk(clk), .rst(rst0), .load_start(start0), .bus(if0),
      .core_rst(core_rst0), .load_done(done0), .load_err(err0)
   );

   prog_loader #(.XLEN(32), .BASE_ADDR(32'h100), .MAX_WORDS(MAXW)) dut1 (
      .clk(clk), .rst(rst1), .load_start(start1), .bus(if1),
      .core_rst(core_rst1), .load_done(done1), .load_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitors: pop one expected write per strobe
   always @(negedge clk) begin
      if (if0.dbg_wr_en === 1'b1) begin
         wr_t e;
         wr_cnt0++;
         chk("wr0_byte_ready", 32'(if0.byte_ready), 32'd0);
         chk("wr0_expected", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("wr0_addr", if0.dbg_addr, e.addr);
            chk("wr0_instr", if0.dbg_instr, e.instr);
         end
      end
   end

   always @(negedge clk) begin
      if (if1.dbg_wr_en === 1'b1) begin
         wr_t e;
         wr_cnt1++;
         chk("wr1_byte_ready", 32'(if1.byte_ready), 32'd0);
         chk("wr1_expected", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("wr1_addr", if1.dbg_addr, e.addr);
            chk("wr1_instr", if1.dbg_instr, e.instr);
         end
      end
   end

   function automatic logic rdy(input int sel);
      return (sel == 0) ? if0.byte_ready : if1.byte_ready;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      if (sel == 0) begin
         if0.byte_valid = v;
         if0.byte_data  = d;
      end else begin
         if1.byte_valid = v;
         if1.byte_data  = d;
      end
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance
   task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
      int n = 0;
      drive(sel, 1'b1, b);
      while (rdy(sel) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(rdy(sel)), 32'd1);
      @(negedge clk);
      drive(sel, 1'b0, 8'h00);
      for (int i = 0; i < gap; i++) @(negedge clk);
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic prog1(input int gap);
      logic [7:0] bytes [14];
      bytes = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hC0, 8'h00,
                8'hA3, 8'h20, 8'h10, 8'h00};
      q0.push_back('{addr: 32'h0, instr: 32'h00000093});
      q0.push_back('{addr: 32'h4, instr: 32'h00C00093});
      q0.push_back('{addr: 32'h8, instr: 32'h001020A3});
      pulse_start(0);
      chk("start_core_rst", 32'(core_rst0), 32'd1);
      chk("start_ready", 32'(if0.byte_ready), 32'd1);
      for (int i = 0; i < 14; i++) send_byte(0, bytes[i], (i == 13) ? 0 : gap);
      chk("last_write_core_rst", 32'(core_rst0), 32'd1);
      @(negedge clk);
      chk("done_core_rst", 32'(core_rst0), 32'd0);
      chk("done_flag", 32'(done0), 32'd1);
      chk("done_q_empty", 32'(q0.size()), 32'd0);
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_ready"}, 32'(if0.byte_ready), 32'd0);
      chk({tag, "_wr_en"}, 32'(if0.dbg_wr_en), 32'd0);
      chk({tag, "_addr"}, if0.dbg_addr, 32'd0);
      chk({tag, "_instr"}, if0.dbg_instr, 32'd0);
      chk({tag, "_core_rst"}, 32'(core_rst0), 32'd1);
      chk({tag, "_done"}, 32'(done0), 32'd0);
      chk({tag, "_err"}, 32'(err0), 32'd0);
   endtask

   initial begin
      int wc;
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk_reset0("reset");
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);

      // 1: three-word program, back-to-back bytes
      prog1(0);
      chk("t1_wr_cnt", 32'(wr_cnt0), 32'd3);

      // 2: empty program
      pulse_start(0);
      chk("t2_start_core_rst", 32'(core_rst0), 32'd1);
      chk("t2_start_done", 32'(done0), 32'd0);
      send_byte(0, 8'h00, 0);
      send_byte(0, 8'h00, 0);
      chk("t2_done", 32'(done0), 32'd1);
      chk("t2_core_rst", 32'(core_rst0), 32'd0);
      chk("t2_ready", 32'(if0.byte_ready), 32'd0);
      chk("t2_wr_cnt", 32'(wr_cnt0), 32'd3);

      // 3: same program with a bubble after every byte
      prog1(1);
      chk("t3_wr_cnt", 32'(wr_cnt0), 32'd6);

      // 4: oversized header N = MAXW + 1 (0x0401)
      pulse_start(0);
      send_byte(0, 8'h01, 0);
      send_byte(0, 8'h04, 0);
      chk("t4_err", 32'(err0), 32'd1);
      chk("t4_core_rst", 32'(core_rst0), 32'd1);
      chk("t4_done", 32'(done0), 32'd0);
      for (int i = 0; i < 5; i++) send_byte(0, 8'(8'hA0 + i), 0);
      chk("t4_drain_ready", 32'(if0.byte_ready), 32'd1);
      chk("t4_err_hold", 32'(err0), 32'd1);
      chk("t4_wr_cnt", 32'(wr_cnt0), 32'd6);

      // 5: reset in the middle of a word, then a clean reload
      pulse_start(0);
      chk("t5_err_clear", 32'(err0), 32'd0);
      chk("t5_core_rst", 32'(core_rst0), 32'd1);
      send_byte(0, 8'h01, 0);
      send_byte(0, 8'h00, 0);
      send_byte(0, 8'h11, 0);
      send_byte(0, 8'h22, 0);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      chk_reset0("t5_rst");
      repeat (3) @(negedge clk);
      chk("t5_wr_cnt", 32'(wr_cnt0), 32'd6);
      chk("t5_idle_ready", 32'(if0.byte_ready), 32'd0);
      prog1(0);
      chk("t5_reload_wr_cnt", 32'(wr_cnt0), 32'd9);

      // 6: restart from DONE with BASE_ADDR = 0x100
      pulse_start(1);
      send_byte(1, 8'h00, 0);
      send_byte(1, 8'h00, 0);
      chk("t6_pre_core_rst", 32'(core_rst1), 32'd0);
      q1.push_back('{addr: 32'h100, instr: 32'hDEADBEEF});
      pulse_start(1);
      chk("t6_start_core_rst", 32'(core_rst1), 32'd1);
      chk("t6_start_done", 32'(done1), 32'd0);
      send_byte(1, 8'h01, 0);
      send_byte(1, 8'h00, 0);
      send_byte(1, 8'hEF, 0);
      send_byte(1, 8'hBE, 0);
      send_byte(1, 8'hAD, 0);
      send_byte(1, 8'hDE, 0);
      chk("t6_write_core_rst", 32'(core_rst1), 32'd1);
      @(negedge clk);
      chk("t6_done_core_rst", 32'(core_rst1), 32'd0);
      chk("t6_done", 32'(done1), 32'd1);
      wc = wr_cnt1;
      chk("t6_wr_cnt", 32'(wc), 32'd1);

      repeat (3) @(negedge clk);
      chk("end_q0_empty", 32'(q0.size()), 32'd0);
      chk("end_q1_empty", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
